// File: rtl/lcd_char_driver.sv
// HD44780 2x16 character LCD driver: power-up wait, init command sequence, then
// endless line 1 / line 2 refresh with characters fetched from an upstream generator.
module lcd_char_driver #(
    parameter int unsigned POWERUP_CYCLES = 40,
    parameter int unsigned E_WIDTH        = 2,
    parameter int unsigned CMD_GAP        = 4,
    parameter int unsigned CLEAR_GAP      = 80,
    parameter int unsigned LINE_LEN       = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] CHAR_DATA,
    output logic       CHAR_ENABLE,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       INIT_DONE
);

    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {POWERUP, INIT, SET_ADDR, WRITE_CHAR} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD, GAP} phase_t;

    state_t          state_q, state_n;
    phase_t          phase_q, phase_n;
    logic [TW-1:0]   tcnt_q, tcnt_n, gap_len;
    logic [1:0]      step_q, step_n;
    logic [5:0]      ccnt_q, ccnt_n;
    logic            line_q, line_n;
    logic [7:0]      data_q, data_n;
    logic            rs_q, rs_n;
    logic            e_q, e_n;
    logic            ce_q, ce_n;
    logic            done_q, done_n;

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        tcnt_n  = tcnt_q;
        step_n  = step_q;
        ccnt_n  = ccnt_q;
        line_n  = line_q;
        data_n  = data_q;
        rs_n    = rs_q;
        done_n  = done_q;
        e_n     = 1'b0;
        ce_n    = 1'b0;
        gap_len = (state_q == INIT && step_q == 2'd3) ? TW'(CLEAR_GAP) : TW'(CMD_GAP);

        if (state_q == POWERUP) begin
            if (tcnt_q == TW'(POWERUP_CYCLES)) begin
                state_n = INIT;
                phase_n = SETUP;
                tcnt_n  = '0;
                step_n  = 2'd0;
                data_n  = init_cmd(2'd0);
                rs_n    = 1'b0;
            end else begin
                tcnt_n = tcnt_q + 16'd1;
            end
        end else begin
            case (phase_q)
                SETUP: begin
                    phase_n = PULSE;
                    tcnt_n  = 16'd1;
                    e_n     = 1'b1;
                    ce_n    = (state_q == WRITE_CHAR);
                end
                PULSE: begin
                    if (tcnt_q == TW'(E_WIDTH)) begin
                        phase_n = HOLD;
                    end else begin
                        tcnt_n = tcnt_q + 16'd1;
                        e_n    = 1'b1;
                    end
                end
                HOLD: begin
                    phase_n = GAP;
                    tcnt_n  = 16'd1;
                end
                default: begin
                    if (tcnt_q == gap_len) begin
                        // Gap end is where the next write's RS/DATA are chosen and latched.
                        phase_n = SETUP;
                        tcnt_n  = '0;
                        case (state_q)
                            INIT: begin
                                if (step_q == 2'd3) begin
                                    state_n = SET_ADDR;
                                    data_n  = 8'h80;
                                    rs_n    = 1'b0;
                                    done_n  = 1'b1;
                                    ccnt_n  = '0;
                                end else begin
                                    step_n = step_q + 2'd1;
                                    data_n = init_cmd(step_q + 2'd1);
                                end
                            end
                            SET_ADDR: begin
                                state_n = WRITE_CHAR;
                                ccnt_n  = '0;
                                data_n  = CHAR_DATA;
                                rs_n    = 1'b1;
                            end
                            WRITE_CHAR: begin
                                if (ccnt_q == 6'(LINE_LEN - 1)) begin
                                    state_n = SET_ADDR;
                                    line_n  = ~line_q;
                                    data_n  = line_q ? 8'h80 : 8'hC0;
                                    rs_n    = 1'b0;
                                    ccnt_n  = '0;
                                end else begin
                                    ccnt_n = ccnt_q + 6'd1;
                                    data_n = CHAR_DATA;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        tcnt_n = tcnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= POWERUP;
            phase_q <= SETUP;
            tcnt_q  <= '0;
            step_q  <= '0;
            ccnt_q  <= '0;
            line_q  <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            tcnt_q  <= tcnt_n;
            step_q  <= step_n;
            ccnt_q  <= ccnt_n;
            line_q  <= line_n;
            data_q  <= data_n;
            rs_q    <= rs_n;
            e_q     <= e_n;
            ce_q    <= ce_n;
            done_q  <= done_n;
        end
    end

    assign CHAR_ENABLE = ce_q;
    assign LCD_E       = e_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = 1'b0;
    assign LCD_DATA    = data_q;
    assign INIT_DONE   = done_q;

endmodule
